// File: rtl/udp_tx.sv
// UDP transmit framer: prepends an 8-byte UDP header to a payload read from a byte RAM.
// Latency: first header byte one cycle after ip_tx_ack; payload byte k at ack+9+k.
// Backpressure: none once granted; the frame streams without gaps until udp_tx_end.
module udp_tx #(
  parameter logic [15:0] LOCAL_PORT_NUM = 16'hF000,
  parameter logic [15:0] DEST_PORT_NUM  = 16'hF000,
  parameter int          MAX_PAYLOAD    = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        udp_send_req,
  input  logic [15:0] udp_send_data_length,
  output logic        udp_send_busy,
  output logic        udp_len_error,
  output logic        udp_tx_req,
  input  logic        ip_tx_ack,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  output logic [15:0] udp_tx_length,
  output logic        udp_ram_rd_en,
  output logic [10:0] udp_ram_raddr,
  input  logic [7:0]  udp_ram_rdata,
  output logic        udp_tx_end
);

  typedef enum logic [2:0] {IDLE, WAIT_ACK, SEND_HEAD, SEND_DATA, END} state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  state_t      state, state_nxt;
  // cnt counts cycles since the grant: cnt == j-1 during cycle ack+j.
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] n_len, n_len_nxt;
  logic [15:0] length_nxt;
  logic [7:0]  data_nxt;
  logic [10:0] raddr_nxt;
  logic        busy_nxt, err_nxt, req_nxt, valid_nxt, rd_en_nxt, end_nxt;
  logic        len_ok;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] ulen);
    case (idx)
      3'd0:    hdr_byte = LOCAL_PORT_NUM[15:8];
      3'd1:    hdr_byte = LOCAL_PORT_NUM[7:0];
      3'd2:    hdr_byte = DEST_PORT_NUM[15:8];
      3'd3:    hdr_byte = DEST_PORT_NUM[7:0];
      3'd4:    hdr_byte = ulen[15:8];
      3'd5:    hdr_byte = ulen[7:0];
      default: hdr_byte = 8'h00;  // checksum left as zero (optional in IPv4)
    endcase
  endfunction

  assign len_ok = (udp_send_data_length != 16'd0) && (udp_send_data_length <= MAX_LEN);

  // State register: reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-cycle output values; all outputs are registered below.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 16'd1;
    n_len_nxt  = n_len;
    length_nxt = udp_tx_length;
    data_nxt   = 8'h00;
    valid_nxt  = 1'b0;
    end_nxt    = 1'b0;
    err_nxt    = 1'b0;
    rd_en_nxt  = 1'b0;
    raddr_nxt  = 11'd0;
    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        if (udp_send_req) begin
          if (len_ok) begin
            n_len_nxt  = udp_send_data_length;
            length_nxt = udp_send_data_length + 16'd8;
            state_nxt  = WAIT_ACK;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        cnt_nxt = 16'd0;
        if (ip_tx_ack) begin
          state_nxt = SEND_HEAD;
          valid_nxt = 1'b1;
          data_nxt  = hdr_byte(3'd0, udp_tx_length);
        end
      end
      SEND_HEAD: begin
        valid_nxt = 1'b1;
        if (cnt < 16'd7) begin
          data_nxt = hdr_byte(cnt[2:0] + 3'd1, udp_tx_length);
        end else begin
          data_nxt  = udp_ram_rdata;
          state_nxt = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (cnt < n_len + 16'd7) begin
          valid_nxt = 1'b1;
          data_nxt  = udp_ram_rdata;
        end else begin
          end_nxt   = 1'b1;
          state_nxt = END;
        end
      end
      END: begin
        cnt_nxt   = 16'd0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 16'd0;
        state_nxt = IDLE;
      end
    endcase
    // RAM reads lead the output by two cycles (one RAM latency, one output register).
    if ((state == SEND_HEAD || state == SEND_DATA) &&
        (cnt >= 16'd5) && (cnt <= n_len + 16'd4)) begin
      rd_en_nxt = 1'b1;
      raddr_nxt = 11'(cnt - 16'd5);
    end
    busy_nxt = (state_nxt != IDLE);
    req_nxt  = (state_nxt == WAIT_ACK);
  end

  // Counters, latched length and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= 16'd0;
      n_len         <= 16'd0;
      udp_tx_length <= 16'd0;
      udp_tx_data   <= 8'h00;
      udp_tx_valid  <= 1'b0;
      udp_tx_end    <= 1'b0;
      udp_len_error <= 1'b0;
      udp_ram_rd_en <= 1'b0;
      udp_ram_raddr <= 11'd0;
      udp_send_busy <= 1'b0;
      udp_tx_req    <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      n_len         <= n_len_nxt;
      udp_tx_length <= length_nxt;
      udp_tx_data   <= data_nxt;
      udp_tx_valid  <= valid_nxt;
      udp_tx_end    <= end_nxt;
      udp_len_error <= err_nxt;
      udp_ram_rd_en <= rd_en_nxt;
      udp_ram_raddr <= raddr_nxt;
      udp_send_busy <= busy_nxt;
      udp_tx_req    <= req_nxt;
    end
  end

endmodule

// File: tb/tb_udp_tx.sv
// Directed-random bench for udp_tx: a RAM responder plus a frame-level reference
// (expected byte list and cycle windows relative to the grant) checked every cycle.
module tb_udp_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        udp_send_req = 1'b0;
  logic [15:0] udp_send_data_length = 16'd0;
  logic        udp_send_busy;
  logic        udp_len_error;
  logic        udp_tx_req;
  logic        ip_tx_ack = 1'b0;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_valid;
  logic [15:0] udp_tx_length;
  logic        udp_ram_rd_en;
  logic [10:0] udp_ram_raddr;
  logic [7:0]  udp_ram_rdata = 8'h00;
  logic        udp_tx_end;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:2047];

  udp_tx dut (
    .clk                  (clk),
    .rst                  (rst),
    .udp_send_req         (udp_send_req),
    .udp_send_data_length (udp_send_data_length),
    .udp_send_busy        (udp_send_busy),
    .udp_len_error        (udp_len_error),
    .udp_tx_req           (udp_tx_req),
    .ip_tx_ack            (ip_tx_ack),
    .udp_tx_data          (udp_tx_data),
    .udp_tx_valid         (udp_tx_valid),
    .udp_tx_length        (udp_tx_length),
    .udp_ram_rd_en        (udp_ram_rd_en),
    .udp_ram_raddr        (udp_ram_raddr),
    .udp_ram_rdata        (udp_ram_rdata),
    .udp_tx_end           (udp_tx_end)
  );

  always #5 clk = ~clk;

  // Payload buffer: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (udp_ram_rd_en) udp_ram_rdata <= ram[udp_ram_raddr];
    else               udp_ram_rdata <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   32'(udp_send_busy), 0);
    chk({tag, "_lenerr"}, 32'(udp_len_error), 0);
    chk({tag, "_txreq"},  32'(udp_tx_req), 0);
    chk({tag, "_data"},   32'(udp_tx_data), 0);
    chk({tag, "_valid"},  32'(udp_tx_valid), 0);
    chk({tag, "_length"}, 32'(udp_tx_length), 0);
    chk({tag, "_rden"},   32'(udp_ram_rd_en), 0);
    chk({tag, "_raddr"},  32'(udp_ram_raddr), 0);
    chk({tag, "_end"},    32'(udp_tx_end), 0);
  endtask

  // One datagram of n bytes, grant after ack_dly waiting cycles; optional extra request
  // while waiting; optional reset at cycle ack+abort_j (0 = no abort).
  task automatic do_frame(input int n, input int ack_dly, input bit extra_req, input int abort_j);
    logic [7:0]  exp_q[$];
    logic [15:0] ulen;
    int vcnt, rcnt;
    bit exp_v, exp_rd;
    logic [7:0] exp_d;
    vcnt = 0;
    rcnt = 0;
    ulen = 16'(n + 8);
    for (int i = 0; i < n; i++) ram[i] = 8'($urandom);
    exp_q = {8'hF0, 8'h00, 8'hF0, 8'h00, ulen[15:8], ulen[7:0], 8'h00, 8'h00};
    for (int i = 0; i < n; i++) exp_q.push_back(ram[i]);

    @(negedge clk);
    udp_send_req = 1'b1;
    udp_send_data_length = 16'(n);
    @(negedge clk);
    udp_send_req = 1'b0;
    chk("accept_busy", 32'(udp_send_busy), 1);
    chk("accept_length", 32'(udp_tx_length), 32'(ulen));
    for (int d = 0; d < ack_dly; d++) begin
      chk("wait_txreq", 32'(udp_tx_req), 1);
      chk("wait_valid", 32'(udp_tx_valid), 0);
      udp_send_req = extra_req && (d == ack_dly / 2);
      udp_send_data_length = 16'd7;
      @(negedge clk);
    end
    udp_send_req = 1'b0;
    chk("grant_txreq", 32'(udp_tx_req), 1);
    ip_tx_ack = 1'b1;
    for (int j = 1; j <= n + 10; j++) begin
      @(negedge clk);
      ip_tx_ack = 1'b0;
      exp_v  = (j <= n + 8);
      exp_d  = exp_v ? exp_q[j-1] : 8'h00;
      exp_rd = (j >= 7) && (j <= n + 6);
      chk("frame_valid", 32'(udp_tx_valid), 32'(exp_v));
      chk("frame_data",  32'(udp_tx_data), 32'(exp_d));
      chk("frame_rden",  32'(udp_ram_rd_en), 32'(exp_rd));
      chk("frame_raddr", 32'(udp_ram_raddr), exp_rd ? 32'(j - 7) : 0);
      chk("frame_end",   32'(udp_tx_end), 32'(j == n + 9));
      chk("frame_busy",  32'(udp_send_busy), 32'(j <= n + 9));
      chk("frame_txreq", 32'(udp_tx_req), 0);
      if (j <= n + 9) chk("frame_length", 32'(udp_tx_length), 32'(ulen));
      if (udp_tx_valid) vcnt++;
      if (udp_ram_rd_en) rcnt++;
      if (j == abort_j) begin
        rst = 1'b1;
        #1;
        chk_zero("abort");
        @(negedge clk);
        chk_zero("abort_hold");
        rst = 1'b0;
        return;
      end
    end
    chk("valid_cycles", 32'(vcnt), 32'(n + 8));
    chk("rden_cycles", 32'(rcnt), 32'(n));
    @(negedge clk);
    chk("after_txreq", 32'(udp_tx_req), 0);
    chk("after_busy", 32'(udp_send_busy), 0);
  endtask

  task automatic len_err(input int n);
    @(negedge clk);
    udp_send_req = 1'b1;
    udp_send_data_length = 16'(n);
    @(negedge clk);
    udp_send_req = 1'b0;
    chk("lenerr_pulse", 32'(udp_len_error), 1);
    chk("lenerr_txreq", 32'(udp_tx_req), 0);
    chk("lenerr_busy", 32'(udp_send_busy), 0);
    @(negedge clk);
    chk("lenerr_clear", 32'(udp_len_error), 0);
    repeat (3) begin
      chk("lenerr_no_txreq", 32'(udp_tx_req), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] b2b_exp[$];
    int ends[$];
    int rises[$];
    bit prev_req;

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    do_frame(4, 0, 1'b0, 0);
    len_err(0);
    len_err(1473);
    do_frame(1472, 0, 1'b0, 0);
    do_frame(int'($urandom_range(2, 64)), 50, 1'b1, 0);
    do_frame(1000, 3, 1'b0, 109);
    do_frame(3, 2, 1'b0, 0);

    // Back-to-back length-1 requests with the request held high.
    ram[0] = 8'($urandom);
    b2b_exp = {8'hF0, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, ram[0]};
    b2b_exp = {b2b_exp, b2b_exp};
    prev_req = 1'b0;
    @(negedge clk);
    udp_send_req = 1'b1;
    udp_send_data_length = 16'd1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (udp_tx_valid) got.push_back(udp_tx_data);
      if (udp_tx_end) ends.push_back(c);
      if (udp_tx_req && !prev_req) rises.push_back(c);
      prev_req = udp_tx_req;
      ip_tx_ack = udp_tx_req;
      if (rises.size() >= 2) udp_send_req = 1'b0;
    end
    ip_tx_ack = 1'b0;
    udp_send_req = 1'b0;
    chk("b2b_bytes", 32'(got.size()), 18);
    chk("b2b_ends", 32'(ends.size()), 2);
    chk("b2b_grants", 32'(rises.size()), 2);
    if (ends.size() >= 1 && rises.size() >= 2)
      chk("b2b_second_accept", 32'(rises[1]), 32'(ends[0] + 2));
    if (got.size() == 18)
      for (int i = 0; i < 18; i++) chk("b2b_data", 32'(got[i]), 32'(b2b_exp[i]));
    chk("b2b_idle_busy", 32'(udp_send_busy), 0);

    for (int r = 0; r < 4; r++)
      do_frame(int'($urandom_range(1, 40)), int'($urandom_range(0, 5)), 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
